sea_result_collector: RTL and testbench
=======================================

# sea_result_collector

Consumer-side companion to the SEA_ALGORITHM core. It keeps a copy of every 256-bit plaintext block handed to the core and captures the core's ciphertext and decrypted results when `enc_complete`/`dec_complete` rise. It checks each decrypted block against its original, keeps match and mismatch counters, and streams the ciphertext out as 32-bit words over a valid/ready interface. It sits between the SEA core and the downstream ciphertext sink or host link.

## Interface
Parameters:
- `DATA_W`, 256: block width; must match the core.
- `OUT_W`, 32: output word width; `DATA_W` must be a multiple of it.
- `DEPTH`, 4: reference FIFO depth in entries; power of two.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `src_valid`  in  1  one-cycle strobe; the block `data_in` has just been presented to the core.
- `data_in`  in  DATA_W  plaintext block copied into the reference FIFO on `src_valid`.
- `enc_complete`  in  1  level signal from the core.
- `dec_complete`  in  1  level signal from the core.
- `enc_data_final`  in  DATA_W  core ciphertext.
- `dec_data_final`  in  DATA_W  core decrypted output.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  sink accepts the word.
- `out_data`  out  OUT_W  ciphertext word.
- `out_last`  out  1  final word of the block.
- `match_cnt`  out  16  decrypted blocks equal to their original.
- `mismatch_cnt`  out  16  decrypted blocks differing from their original, plus underflow events.
- `err_flags`  out  3  sticky flags: [0] FIFO overflow, [1] FIFO underflow, [2] completion overrun.
- `busy`  out  1  state is not WAIT, or the FIFO is not empty.
- `lat_cycles`  out  32  cycles from push to check for the last checked block.

## Operation
- Reference FIFO:
  - `src_valid` with FIFO not full: push `data_in`, plus a timestamp when the latency counter is compiled in.
  - `src_valid` with FIFO full: drop the block and set `err_flags[0]`.
- Completion detect:
  - A one-cycle rise detector runs on each of `enc_complete` and `dec_complete`.
  - On the rise, the matching data bus is registered into `enc_q` or `dec_q`, and flag `enc_seen` or `dec_seen` is set.
  - Both rising in the same cycle is legal; both buses are captured.
  - A rise on a side whose seen-flag is already set: overwrite that register and set `err_flags[2]`.
- FSM states: WAIT, CHECK, STREAM.
  - WAIT → CHECK when `enc_seen` and `dec_seen` are both set.
  - CHECK, one cycle:
    - FIFO non-empty: compare `dec_q` with the FIFO head, increment `match_cnt` or `mismatch_cnt`, pop the FIFO, update `lat_cycles`.
    - FIFO empty: increment `mismatch_cnt` and set `err_flags[1]`.
    - In both cases: clear both seen-flags, load `enc_q` into the shift register, word index = 0, go to STREAM.
  - STREAM:
    - Present word `enc_q[DATA_W-1-idx*OUT_W -: OUT_W]`, most-significant word first.
    - Advance the index on `out_valid && out_ready`.
    - `out_last` = 1 on word `DATA_W/OUT_W-1`. Its handshake returns the FSM to WAIT.
- Rises of the complete signals during CHECK or STREAM are captured normally, so one block can be pending. A second pending rise on the same side is an overrun.
- Counters saturate at 16'hFFFF.
- `err_flags` bits clear only on reset.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `match_cnt`=0, `mismatch_cnt`=0, `err_flags`=0, `busy`=0, `lat_cycles`=0. FIFO empty, state WAIT.
- Reset asserted mid-stream aborts immediately. `out_valid` drops asynchronously and all captured data is discarded.
- Latency sequence, with the second required rise sampled at edge N:
  - seen-flag set at N;
  - CHECK at N+1;
  - `out_valid`=1 at N+2.
- Counters update at the end of the CHECK cycle.
- `out_data`, `out_last` and `out_valid` are registered and stay stable while `out_valid && !out_ready`.
- With `out_ready` tied to 1, a block streams in `DATA_W/OUT_W` consecutive cycles (8 with the defaults).
- `src_valid` in the same cycle as a CHECK pop on a full FIFO: the push is accepted and there is no overflow.

## Configuration
- `SEA_LATENCY_CNT_EN` defined:
  - a 32-bit free-running cycle counter runs, wrapping modulo 2^32;
  - each FIFO entry stores the counter value at push;
  - at CHECK, `lat_cycles` = counter − head timestamp, modulo 2^32.
- Not defined: no counter and no timestamp storage; `lat_cycles` is tied to 0.

## Test plan
- Basic block:
  - Stimulus: push 256'h185; drive `enc_data_final`=256'hABCD and `dec_data_final`=256'h185; raise both completes in the same cycle; `out_ready`=1.
  - Required: `match_cnt`=1; 8 words, words 0–6 = 0 and word 7 = 32'h0000ABCD with `out_last`; `out_valid` first high 2 cycles after the rise.
- Mismatch and ordering:
  - Stimulus: push 256'h1; `enc_complete` rises; 5 cycles later `dec_complete` rises with `dec_data_final`=256'h2.
  - Required: `mismatch_cnt`=1; CHECK occurs only after the dec rise.
- Backpressure:
  - Stimulus: `out_ready` toggles 1/0 each cycle.
  - Required: 8 words delivered in order; `out_data` stable while stalled; next block pending until STREAM ends.
- FIFO limits:
  - Stimulus: 5 pushes with `DEPTH`=4; then a completion pair with the FIFO empty.
  - Required: `err_flags[0]`=1 (5th push dropped) and, after the empty-FIFO completion pair, `err_flags[1]`=1 with `mismatch_cnt` incremented.
- Overrun and reset:
  - Stimulus: two `enc_complete` rises with no `dec_complete` between them; then `reset`=0 during STREAM.
  - Required: `err_flags[2]`=1; after reset all outputs at their reset values immediately.
- Latency (`SEA_LATENCY_CNT_EN` defined):
  - Stimulus: push at cycle 10, second completion rise sampled at cycle 30.
  - Required: `lat_cycles`=21.

Source files
------------

// File: rtl/sea_result_collector.sv
`default_nettype none
// sea_result_collector: checks SEA core decrypt results against stored plaintext and streams ciphertext words.
// Optional macro SEA_LATENCY_CNT_EN adds push-to-check latency measurement.  Rev 1.0
module sea_result_collector #(
  parameter int DATA_W = 256,
  parameter int OUT_W  = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enc_complete,
  input  logic              dec_complete,
  input  logic [DATA_W-1:0] enc_data_final,
  input  logic [DATA_W-1:0] dec_data_final,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic [15:0]       match_cnt,
  output logic [15:0]       mismatch_cnt,
  output logic [2:0]        err_flags,
  output logic              busy,
  output logic [31:0]       lat_cycles
);
  localparam int WORDS = DATA_W / OUT_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(WORDS - 2);

  typedef enum logic [1:0] {WAIT = 2'd0, CHECK = 2'd1, STREAM = 2'd2} state_t;
  state_t state;

  logic              enc_prev, dec_prev, enc_seen, dec_seen;
  logic              enc_rise, dec_rise;
  logic [DATA_W-1:0] enc_q, dec_q, shift_q;
  logic [IDX_W-1:0]  idx;
  logic              ovf_err, unf_err, ovr_err;

  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              fifo_empty, fifo_full, push, pop;

  assign enc_rise   = enc_complete & ~enc_prev;
  assign dec_rise   = dec_complete & ~dec_prev;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pop        = (state == CHECK) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push       = src_valid && (!fifo_full || pop);
  assign busy       = (state != WAIT) || !fifo_empty;
  assign err_flags  = {ovr_err, unf_err, ovf_err};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (src_valid && !push) ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_in;
  end

  // CHECK consumes the seen-flags; a rise in that same cycle starts the next pending block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enc_prev <= 1'b0;
      dec_prev <= 1'b0;
      enc_seen <= 1'b0;
      dec_seen <= 1'b0;
      enc_q    <= '0;
      dec_q    <= '0;
      ovr_err  <= 1'b0;
    end else begin
      enc_prev <= enc_complete;
      dec_prev <= dec_complete;
      if (state == CHECK) begin
        enc_seen <= 1'b0;
        dec_seen <= 1'b0;
      end
      if (enc_rise) begin
        enc_q    <= enc_data_final;
        enc_seen <= 1'b1;
        if (enc_seen && state != CHECK) ovr_err <= 1'b1;
      end
      if (dec_rise) begin
        dec_q    <= dec_data_final;
        dec_seen <= 1'b1;
        if (dec_seen && state != CHECK) ovr_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= WAIT;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      unf_err      <= 1'b0;
      shift_q      <= '0;
      idx          <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (enc_seen && dec_seen) state <= CHECK;
        end
        CHECK: begin
          if (!fifo_empty && dec_q == fifo_mem[rd_ptr])
            match_cnt <= (match_cnt == 16'hFFFF) ? match_cnt : match_cnt + 16'd1;
          else
            mismatch_cnt <= (mismatch_cnt == 16'hFFFF) ? mismatch_cnt : mismatch_cnt + 16'd1;
          if (fifo_empty) unf_err <= 1'b1;
          out_data  <= enc_q[DATA_W-1 -: OUT_W];
          shift_q   <= enc_q << OUT_W;
          out_valid <= 1'b1;
          out_last  <= (WORDS == 1);
          idx       <= '0;
          state     <= STREAM;
        end
        STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              state     <= WAIT;
            end else begin
              out_data <= shift_q[DATA_W-1 -: OUT_W];
              shift_q  <= shift_q << OUT_W;
              idx      <= idx + 1'b1;
              out_last <= (idx == PRE_LAST);
            end
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

`ifdef SEA_LATENCY_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt  <= '0;
      lat_cycles <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (pop) lat_cycles <= cycle_cnt - ts_mem[rd_ptr];
    end
  end

  // Timestamp is the counter value after the push edge, so push and check edges count inclusively.
  always_ff @(posedge clk) begin
    if (push) ts_mem[wr_ptr] <= cycle_cnt + 32'd1;
  end
`else
  assign lat_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sea_result_collector.sv
`default_nettype none
// Bench for sea_result_collector: vector table, directed corner sequences, randomized run against a block-level model.
module tb_sea_result_collector;
  localparam int DATA_W = 256;
  localparam int OUT_W  = 32;
  localparam int DEPTH  = 4;
  localparam int WORDS  = DATA_W / OUT_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              src_valid;
  logic [DATA_W-1:0] data_in;
  logic              enc_complete, dec_complete;
  logic [DATA_W-1:0] enc_data_final, dec_data_final;
  logic              out_valid, out_ready, out_last, busy;
  logic [OUT_W-1:0]  out_data;
  logic [15:0]       match_cnt, mismatch_cnt;
  logic [2:0]        err_flags;
  logic [31:0]       lat_cycles;

  sea_result_collector #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .data_in(data_in),
    .enc_complete(enc_complete), .dec_complete(dec_complete),
    .enc_data_final(enc_data_final), .dec_data_final(dec_data_final),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .err_flags(err_flags),
    .busy(busy), .lat_cycles(lat_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  typedef struct {
    logic [255:0] plain;
    logic [255:0] enc;
    logic [255:0] dec;
    int           gap;
    bit           dec_first;
    logic [15:0]  exp_match;
    logic [15:0]  exp_mism;
    logic [31:0]  exp_w0;
    logic [31:0]  exp_w7;
  } vec_t;

  int          n_chk = 0;
  int          n_pass = 0;
  word_t       exp_q[$];
  logic [31:0] got_words[$];
  bit          stall_pending = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;
  bit          toggle_ready = 1'b0;
  bit          rand_ready = 1'b0;
  vec_t        vecs[4];

  logic [255:0] m_q[$];
  int           m_match, m_mism;
  bit           m_ovf, m_unf;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at a falling edge with inputs already set; observes what the next rising edge will accept.
  task automatic step();
    if (stall_pending) begin
      chk("stall_valid", 256'(out_valid), 256'(1'b1));
      chk("stall_data", 256'(out_data), 256'(stall_data));
      chk("stall_last", 256'(out_last), 256'(stall_last));
    end
    stall_pending = out_valid && !out_ready;
    stall_data    = out_data;
    stall_last    = out_last;
    if (out_valid && out_ready) begin
      got_words.push_back(out_data);
      chk("word_expected", 256'(exp_q.size() != 0), 256'(1'b1));
      if (exp_q.size() != 0) begin
        word_t w;
        w = exp_q.pop_front();
        chk("word_data", 256'(out_data), 256'(w.data));
        chk("word_last", 256'(out_last), 256'(w.last));
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (toggle_ready) out_ready = ~out_ready;
    else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    src_valid = 1'b0; data_in = '0;
    enc_complete = 1'b0; dec_complete = 1'b0;
    enc_data_final = '0; dec_data_final = '0;
    out_ready = 1'b1; toggle_ready = 1'b0; rand_ready = 1'b0;
    stall_pending = 1'b0;
    exp_q.delete(); got_words.delete();
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic push(input logic [255:0] d);
    src_valid = 1'b1; data_in = d;
    step();
    src_valid = 1'b0;
  endtask

  task automatic exp_push(input logic [255:0] e);
    for (int k = 0; k < WORDS; k++)
      exp_q.push_back('{data: e[DATA_W-1-OUT_W*k -: OUT_W], last: (k == WORDS-1)});
  endtask

  task automatic complete_pair(input logic [255:0] e, input logic [255:0] d, input int gap, input bit dec_first);
    enc_data_final = e; dec_data_final = d;
    if (gap == 0) begin
      enc_complete = 1'b1; dec_complete = 1'b1;
      step();
      enc_complete = 1'b0; dec_complete = 1'b0;
    end else begin
      if (dec_first) dec_complete = 1'b1; else enc_complete = 1'b1;
      step();
      enc_complete = 1'b0; dec_complete = 1'b0;
      for (int k = 1; k < gap; k++) step();
      chk("no_early_check", 256'(out_valid), 256'(1'b0));
      if (dec_first) enc_complete = 1'b1; else dec_complete = 1'b1;
      step();
      enc_complete = 1'b0; dec_complete = 1'b0;
    end
  endtask

  task automatic wait_out(output int c);
    c = 0;
    while (!out_valid && c < 10) begin
      step();
      c++;
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 300) begin
      step();
      c++;
    end
    chk("drain_done", 256'(exp_q.size() != 0 || out_valid), 256'(1'b0));
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{plain: 256'h185, enc: 256'hABCD, dec: 256'h185, gap: 0, dec_first: 1'b0,
                exp_match: 16'd1, exp_mism: 16'd0, exp_w0: 32'h0, exp_w7: 32'h0000ABCD};
    vecs[1] = '{plain: 256'h1,
                enc: 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888,
                dec: 256'h2, gap: 5, dec_first: 1'b0,
                exp_match: 16'd1, exp_mism: 16'd1, exp_w0: 32'h11111111, exp_w7: 32'h88888888};
    vecs[2] = '{plain: {256{1'b1}}, enc: 256'hDEADBEEF << 224, dec: {256{1'b1}}, gap: 3, dec_first: 1'b1,
                exp_match: 16'd2, exp_mism: 16'd1, exp_w0: 32'hDEADBEEF, exp_w7: 32'h0};
    vecs[3] = '{plain: 256'h5, enc: {32'hA0A0A0A0, 192'h0, 32'h5A5A5A5A}, dec: 256'h5 | (256'h1 << 255),
                gap: 1, dec_first: 1'b0,
                exp_match: 16'd2, exp_mism: 16'd2, exp_w0: 32'hA0A0A0A0, exp_w7: 32'h5A5A5A5A};

    do_reset();
    chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_out_data", 256'(out_data), 256'(32'h0));
    chk("rst_out_last", 256'(out_last), 256'(1'b0));
    chk("rst_match", 256'(match_cnt), 256'(16'h0));
    chk("rst_mismatch", 256'(mismatch_cnt), 256'(16'h0));
    chk("rst_err", 256'(err_flags), 256'(3'b000));
    chk("rst_busy", 256'(busy), 256'(1'b0));
    chk("rst_lat", 256'(lat_cycles), 256'(32'h0));

    for (int i = 0; i < 4; i++) begin
      int lat;
      got_words.delete();
      push(vecs[i].plain);
      chk("busy_after_push", 256'(busy), 256'(1'b1));
      exp_push(vecs[i].enc);
      complete_pair(vecs[i].enc, vecs[i].dec, vecs[i].gap, vecs[i].dec_first);
      wait_out(lat);
      chk("rise_to_valid", 256'(lat), 256'(2));
      drain();
      chk("tbl_match", 256'(match_cnt), 256'(vecs[i].exp_match));
      chk("tbl_mismatch", 256'(mismatch_cnt), 256'(vecs[i].exp_mism));
      chk("tbl_word_count", 256'(got_words.size()), 256'(WORDS));
      if (got_words.size() == WORDS) begin
        chk("tbl_w0", 256'(got_words[0]), 256'(vecs[i].exp_w0));
        chk("tbl_w7", 256'(got_words[7]), 256'(vecs[i].exp_w7));
      end
      chk("tbl_busy_idle", 256'(busy), 256'(1'b0));
    end

    // Latency: push sampled at edge P, second rise sampled at edge P+20.
    push(256'h33);
    for (int k = 0; k < 19; k++) step();
    exp_push(256'h44);
    complete_pair(256'h44, 256'h33, 0, 1'b0);
    drain();
`ifdef SEA_LATENCY_CNT_EN
    chk("lat_cycles", 256'(lat_cycles), 256'(32'd21));
`else
    chk("lat_cycles_off", 256'(lat_cycles), 256'(32'd0));
`endif

    // FIFO limits: overflow on the fifth push, underflow on an empty-FIFO completion.
    do_reset();
    for (int i = 0; i < 5; i++) push(256'(i + 100));
    chk("ovf_flag", 256'(err_flags), 256'(3'b001));
    for (int i = 0; i < 4; i++) begin
      exp_push(256'(i + 10));
      complete_pair(256'(i + 10), 256'(i + 100), 0, 1'b0);
      drain();
    end
    chk("fifo_match", 256'(match_cnt), 256'(16'd4));
    exp_push(256'h99);
    complete_pair(256'h99, 256'h100, 0, 1'b0);
    drain();
    chk("unf_mismatch", 256'(mismatch_cnt), 256'(16'd1));
    chk("unf_flags", 256'(err_flags), 256'(3'b011));
    chk("unf_busy", 256'(busy), 256'(1'b0));

    // Push into a full FIFO during the CHECK pop is accepted.
    do_reset();
    for (int i = 0; i < 4; i++) push(256'(i + 200));
    exp_push(256'hE0);
    complete_pair(256'hE0, 256'd200, 0, 1'b0);
    step();
    src_valid = 1'b1; data_in = 256'd204;
    step();
    src_valid = 1'b0;
    chk("no_ovf_pop_push", 256'(err_flags), 256'(3'b000));
    drain();
    for (int i = 1; i < 5; i++) begin
      exp_push(256'(i));
      complete_pair(256'(i), 256'(i + 200), 0, 1'b0);
      drain();
    end
    chk("popush_match", 256'(match_cnt), 256'(16'd5));
    chk("popush_mismatch", 256'(mismatch_cnt), 256'(16'd0));

    // Backpressure with a second block pending behind the stream.
    do_reset();
    push(256'hA1);
    push(256'hB2);
    exp_push(vecs[1].enc);
    complete_pair(vecs[1].enc, 256'hA1, 0, 1'b0);
    toggle_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    exp_push(vecs[3].enc);
    complete_pair(vecs[3].enc, 256'hB2, 0, 1'b0);
    drain();
    toggle_ready = 1'b0;
    out_ready = 1'b1;
    chk("bp_word_count", 256'(got_words.size()), 256'(2 * WORDS));
    chk("bp_match", 256'(match_cnt), 256'(16'd2));

    // Overrun, then asynchronous reset in the middle of a stalled stream.
    do_reset();
    push(256'h77);
    enc_data_final = 256'h1111; enc_complete = 1'b1; step(); enc_complete = 1'b0; step();
    enc_data_final = 256'h2222; enc_complete = 1'b1; step(); enc_complete = 1'b0;
    chk("overrun_flag", 256'(err_flags), 256'(3'b100));
    out_ready = 1'b0;
    dec_data_final = 256'h77; dec_complete = 1'b1; step(); dec_complete = 1'b0;
    step(); step();
    chk("stream_before_rst", 256'(out_valid), 256'(1'b1));
    chk("match_before_rst", 256'(match_cnt), 256'(16'd1));
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("arst_out_data", 256'(out_data), 256'(32'h0));
    chk("arst_out_last", 256'(out_last), 256'(1'b0));
    chk("arst_match", 256'(match_cnt), 256'(16'h0));
    chk("arst_mismatch", 256'(mismatch_cnt), 256'(16'h0));
    chk("arst_err", 256'(err_flags), 256'(3'b000));
    chk("arst_busy", 256'(busy), 256'(1'b0));
    chk("arst_lat", 256'(lat_cycles), 256'(32'h0));
    stall_pending = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    step();

    // Randomized blocks against a queue-level model.
    do_reset();
    rand_ready = 1'b1;
    m_q.delete();
    m_match = 0; m_mism = 0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int b = 0; b < 25; b++) begin
      int np, g;
      bit df;
      logic [255:0] e, d;
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) begin
        d = rand256();
        push(d);
        if (m_q.size() >= DEPTH) m_ovf = 1'b1;
        else m_q.push_back(d);
      end
      e = rand256();
      if (m_q.size() != 0 && $urandom_range(0, 2) != 0) d = m_q[0];
      else d = rand256();
      if (m_q.size() != 0) begin
        if (m_q.pop_front() == d) m_match++;
        else m_mism++;
      end else begin
        m_mism++;
        m_unf = 1'b1;
      end
      exp_push(e);
      g  = $urandom_range(0, 3);
      df = ($urandom_range(0, 1) == 1);
      complete_pair(e, d, g, df);
      drain();
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    chk("rnd_match", 256'(match_cnt), 256'(m_match[15:0]));
    chk("rnd_mismatch", 256'(mismatch_cnt), 256'(m_mism[15:0]));
    chk("rnd_err", 256'(err_flags), 256'({1'b0, m_unf, m_ovf}));
    chk("rnd_busy", 256'(busy), 256'(m_q.size() != 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
